modbus_rtu_frame_ctrl: RTL and testbench

//  Modbus RTU slave frame sequencer sitting between uart_bridge (RTU byte stream + frame events) and the register/coil app.

---
 rtl/modbus_pkg.sv | 34 +++
 rtl/crc16_modbus.sv | 25 ++
 rtl/modbus_rtu_frame_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_modbus_rtu_frame_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modbus_pkg.sv
// Modbus RTU frame controller shared types and constants.
// CRC-16/MODBUS byte update helper lives here too.
package modbus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_DELIVER,
    S_WAIT_RSP,
    S_TX_DATA,
    S_TX_CRC_LO,
    S_TX_CRC_HI
  } state_t;

  localparam logic [15:0] CRC_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC_POLY   = 16'hA001;
  localparam int          MIN_FRAME  = 4;
  localparam logic [7:0]  ADDR_BCAST = 8'h00;

  // Reflected CRC-16 update, one full byte per call.
  function automatic logic [15:0] crc16_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc16_modbus.sv
// CRC-16/MODBUS accumulator, one byte per cycle.
// init with en in the same cycle folds the byte into a fresh seed.
module crc16_modbus
  import modbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  // Seed or fold one byte into the running CRC.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_byte(init ? CRC_INIT : crc, data);
    end else if (init) begin
      crc <= CRC_INIT;
    end
  end

endmodule

// File: rtl/modbus_rtu_frame_ctrl.sv
// Modbus RTU slave frame sequencer: RX buffer, CRC/address check,
// app handoff, and TX streaming with appended CRC.
module modbus_rtu_frame_ctrl
  import modbus_pkg::*;
#(
  parameter  int BUF_DEPTH = 256,
  parameter  int TX_GUARD  = 2,
  localparam int AW        = $clog2(BUF_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    slave_addr_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  input  logic          frame_start_i,
  input  logic          frame_end_i,
  output logic [7:0]    tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  output logic          req_valid_o,
  output logic [AW:0]   req_len_o,
  output logic          req_bcast_o,
  input  logic [AW-1:0] req_rd_addr_i,
  output logic [7:0]    req_rd_data_o,
  input  logic          req_ack_i,
  input  logic          rsp_wr_en_i,
  input  logic [AW-1:0] rsp_wr_addr_i,
  input  logic [7:0]    rsp_wr_data_i,
  input  logic          rsp_start_i,
  input  logic [AW:0]   rsp_len_i,
  output logic          busy_o,
  output logic          crc_err_o,
  output logic          short_err_o,
  output logic          overrun_o,
  output logic          drop_o
);

  localparam int GW = $clog2(TX_GUARD + 2);
  localparam logic [AW:0] DEPTH = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  state_t        state;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   rd_ptr_nxt;
  logic [AW:0]   tx_len;
  logic [GW-1:0] guard;
  logic          ovf;
  logic          drop_done;
  logic [7:0]    addr_q;
  logic [7:0]    tx_q;

  logic [7:0]    rx_mem [BUF_DEPTH];
  logic [7:0]    tx_mem [BUF_DEPTH];

  logic          rx_open;
  logic          rx_take;
  logic [AW-1:0] rx_waddr;
  logic          in_tx;
  logic          in_post;
  logic          tx_fire;

  logic          crc_init;
  logic          crc_en;
  logic [7:0]    crc_data;
  logic [15:0]   crc;

  assign busy_o = (state != S_IDLE);

  assign rx_open = (state == S_RECV) ||
                   (state == S_IDLE && frame_start_i);
  assign rx_take = rx_valid_i && rx_open &&
                   (frame_start_i || wr_ptr != DEPTH);
  assign rx_waddr = frame_start_i ? '0 : wr_ptr[AW-1:0];

  assign in_tx = (state == S_TX_DATA) ||
                 (state == S_TX_CRC_LO) ||
                 (state == S_TX_CRC_HI);
  assign in_post = in_tx ||
                   (state == S_DELIVER) ||
                   (state == S_WAIT_RSP);
  assign tx_fire = in_tx && tx_ready_i && (guard == '0);

  // One CRC engine shared: RX and TX phases never overlap.
  assign crc_init = (frame_start_i &&
                     (state == S_IDLE || state == S_RECV)) ||
                    (state == S_WAIT_RSP && rsp_start_i);
  assign crc_en   = rx_take ||
                    (tx_fire && state == S_TX_DATA);
  assign crc_data = (state == S_TX_DATA) ? tx_q : rx_data_i;

  crc16_modbus u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .data (crc_data),
    .crc  (crc)
  );

  // Next TX read pointer, used to prefetch the TX buffer.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (state == S_WAIT_RSP && rsp_start_i) begin
      rd_ptr_nxt = '0;
    end else if (state == S_TX_DATA && tx_fire) begin
      rd_ptr_nxt = rd_ptr + ONE;
    end
  end

  // RX buffer write port (controller side).
  always_ff @(posedge clk) begin
    if (rx_take) begin
      rx_mem[rx_waddr] <= rx_data_i;
    end
  end

  // RX buffer read port (app side), 1-cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_rd_data_o <= '0;
    end else begin
      req_rd_data_o <= rx_mem[req_rd_addr_i];
    end
  end

  // TX buffer write port (app side).
  always_ff @(posedge clk) begin
    if (rsp_wr_en_i) begin
      tx_mem[rsp_wr_addr_i] <= rsp_wr_data_i;
    end
  end

  // TX buffer prefetch so the current byte is ready on fire.
  always_ff @(posedge clk) begin
    tx_q <= tx_mem[rd_ptr_nxt[AW-1:0]];
  end

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tx_len      <= '0;
      guard       <= '0;
      ovf         <= 1'b0;
      drop_done   <= 1'b0;
      addr_q      <= '0;
      tx_data_o   <= '0;
      tx_valid_o  <= 1'b0;
      req_valid_o <= 1'b0;
      req_len_o   <= '0;
      req_bcast_o <= 1'b0;
      crc_err_o   <= 1'b0;
      short_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      drop_o      <= 1'b0;
    end else begin
      tx_valid_o  <= 1'b0;
      crc_err_o   <= 1'b0;
      short_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      drop_o      <= 1'b0;
      rd_ptr      <= rd_ptr_nxt;

      if (guard != '0) begin
        guard <= guard - GW'(1);
      end

      if (rx_take && rx_waddr == '0) begin
        addr_q <= rx_data_i;
      end

      if (frame_start_i) begin
        drop_done <= 1'b0;
      end

      if (frame_end_i && in_post && !drop_done) begin
        drop_o    <= 1'b1;
        drop_done <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (frame_start_i) begin
            state  <= S_RECV;
            ovf    <= 1'b0;
            wr_ptr <= rx_take ? ONE : '0;
          end
        end
        S_RECV: begin
          if (frame_start_i) begin
            ovf    <= 1'b0;
            wr_ptr <= rx_take ? ONE : '0;
          end else begin
            if (rx_take) begin
              wr_ptr <= wr_ptr + ONE;
            end else if (rx_valid_i) begin
              ovf <= 1'b1;
            end
            if (frame_end_i) begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          state <= S_IDLE;
          if (ovf) begin
            overrun_o <= 1'b1;
          end else if (wr_ptr < (AW+1)'(MIN_FRAME)) begin
            short_err_o <= 1'b1;
          end else if (crc != 16'h0000) begin
            crc_err_o <= 1'b1;
          end else if (addr_q == slave_addr_i ||
                       addr_q == ADDR_BCAST) begin
            req_valid_o <= 1'b1;
            req_len_o   <= wr_ptr - (AW+1)'(2);
            req_bcast_o <= (addr_q == ADDR_BCAST);
            state       <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          if (req_ack_i) begin
            req_valid_o <= 1'b0;
            state <= req_bcast_o ? S_IDLE : S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_start_i) begin
            if (rsp_len_i == '0) begin
              state <= S_IDLE;
            end else begin
              tx_len <= rsp_len_i;
              state  <= S_TX_DATA;
            end
          end
        end
        S_TX_DATA: begin
          if (tx_fire) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= tx_q;
            guard      <= GW'(TX_GUARD);
            if (rd_ptr + ONE == tx_len) begin
              state <= S_TX_CRC_LO;
            end
          end
        end
        S_TX_CRC_LO: begin
          if (tx_fire) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= crc[7:0];
            guard      <= GW'(TX_GUARD);
            state      <= S_TX_CRC_HI;
          end
        end
        S_TX_CRC_HI: begin
          if (tx_fire) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= crc[15:8];
            guard      <= GW'(TX_GUARD);
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_rtu_frame_ctrl.sv
// Directed bench for modbus_rtu_frame_ctrl (BUF_DEPTH=8).
// Frames, responses, error paths and reset mid-TX.
module tb_modbus_rtu_frame_ctrl;

  localparam int BD = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    slave_addr_i = 8'h01;
  logic [7:0]    rx_data_i = '0;
  logic          rx_valid_i = 1'b0;
  logic          frame_start_i = 1'b0;
  logic          frame_end_i = 1'b0;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b0;
  logic          req_valid_o;
  logic [AW:0]   req_len_o;
  logic          req_bcast_o;
  logic [AW-1:0] req_rd_addr_i = '0;
  logic [7:0]    req_rd_data_o;
  logic          req_ack_i = 1'b0;
  logic          rsp_wr_en_i = 1'b0;
  logic [AW-1:0] rsp_wr_addr_i = '0;
  logic [7:0]    rsp_wr_data_i = '0;
  logic          rsp_start_i = 1'b0;
  logic [AW:0]   rsp_len_i = '0;
  logic          busy_o;
  logic          crc_err_o;
  logic          short_err_o;
  logic          overrun_o;
  logic          drop_o;

  modbus_rtu_frame_ctrl #(.BUF_DEPTH(BD), .TX_GUARD(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .slave_addr_i  (slave_addr_i),
    .rx_data_i     (rx_data_i),
    .rx_valid_i    (rx_valid_i),
    .frame_start_i (frame_start_i),
    .frame_end_i   (frame_end_i),
    .tx_data_o     (tx_data_o),
    .tx_valid_o    (tx_valid_o),
    .tx_ready_i    (tx_ready_i),
    .req_valid_o   (req_valid_o),
    .req_len_o     (req_len_o),
    .req_bcast_o   (req_bcast_o),
    .req_rd_addr_i (req_rd_addr_i),
    .req_rd_data_o (req_rd_data_o),
    .req_ack_i     (req_ack_i),
    .rsp_wr_en_i   (rsp_wr_en_i),
    .rsp_wr_addr_i (rsp_wr_addr_i),
    .rsp_wr_data_i (rsp_wr_data_i),
    .rsp_start_i   (rsp_start_i),
    .rsp_len_i     (rsp_len_i),
    .busy_o        (busy_o),
    .crc_err_o     (crc_err_o),
    .short_err_o   (short_err_o),
    .overrun_o     (overrun_o),
    .drop_o        (drop_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fb [16];
  logic [7:0] txq [$];
  int cyc = 0;
  int last_tx = -100;
  int min_gap = 1000;
  int n_crc = 0;
  int n_short = 0;
  int n_ovr = 0;
  int n_drop = 0;

  // Observe pulses away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (tx_valid_o) begin
      txq.push_back(tx_data_o);
      if (cyc - last_tx < min_gap) min_gap = cyc - last_tx;
      last_tx = cyc;
    end
    if (crc_err_o) n_crc++;
    if (short_err_o) n_short++;
    if (overrun_o) n_ovr++;
    if (drop_o) n_drop++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int n);
    frame_start_i = 1'b1;
    rx_valid_i = 1'b1;
    rx_data_i = fb[0];
    tick();
    frame_start_i = 1'b0;
    for (int k = 1; k < n; k++) begin
      rx_data_i = fb[k];
      tick();
    end
    rx_valid_i = 1'b0;
    frame_end_i = 1'b1;
    tick();
    frame_end_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic load_good(input logic [7:0] a);
    logic [15:0] c;
    fb[0] = a; fb[1] = 8'h03; fb[2] = 8'h00;
    fb[3] = 8'h00; fb[4] = 8'h00; fb[5] = 8'h01;
    c = crc_ref(6);
    fb[6] = c[7:0];
    fb[7] = c[15:8];
  endtask

  // Bit-serial reference CRC-16/MODBUS over fb[0..n-1].
  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] c;
    logic mix;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 8; b++) begin
        mix = c[0] ^ fb[k][b];
        c = c >> 1;
        if (mix) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic wait_idle(input string tag, input int max);
    int k;
    k = 0;
    while (busy_o && k < max) begin
      tick();
      k++;
    end
    chk(tag, 32'(busy_o), 32'd0);
  endtask

  logic [7:0] exp_rx [6];
  logic [7:0] exp_tx [7];
  logic [7:0] rsp [5];
  int base;
  int k;

  initial begin
    exp_rx = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
    exp_tx = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h00,
               8'hB8, 8'h44};
    rsp = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h00};

    repeat (3) tick();
    chk("rst_tx_valid", 32'(tx_valid_o), 0);
    chk("rst_tx_data", 32'(tx_data_o), 0);
    chk("rst_req_valid", 32'(req_valid_o), 0);
    chk("rst_req_len", 32'(req_len_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rst = 1'b0;
    tick();

    // Good request to slave 01.
    fb[0] = 8'h01; fb[1] = 8'h03; fb[2] = 8'h00;
    fb[3] = 8'h00; fb[4] = 8'h00; fb[5] = 8'h01;
    fb[6] = 8'h84; fb[7] = 8'h0A;
    send_frame(8);
    chk("good_req_valid", 32'(req_valid_o), 1);
    chk("good_req_len", 32'(req_len_o), 6);
    chk("good_bcast", 32'(req_bcast_o), 0);
    chk("good_busy", 32'(busy_o), 1);
    chk("good_no_err", 32'(n_crc + n_short + n_ovr + n_drop), 0);
    for (int i = 0; i < 6; i++) begin
      req_rd_addr_i = AW'(i);
      tick();
      chk($sformatf("rx_buf%0d", i),
          32'(req_rd_data_o), 32'(exp_rx[i]));
    end
    req_ack_i = 1'b1;
    tick();
    req_ack_i = 1'b0;
    chk("ack_drop_valid", 32'(req_valid_o), 0);
    chk("wait_rsp_busy", 32'(busy_o), 1);

    // Response with CRC append, ready held high.
    for (int i = 0; i < 5; i++) begin
      rsp_wr_en_i = 1'b1;
      rsp_wr_addr_i = AW'(i);
      rsp_wr_data_i = rsp[i];
      tick();
    end
    rsp_wr_en_i = 1'b0;
    tx_ready_i = 1'b1;
    rsp_start_i = 1'b1;
    rsp_len_i = 4'd5;
    tick();
    rsp_start_i = 1'b0;
    wait_idle("tx_idle_timeout", 200);
    tick();
    chk("tx_count", 32'(txq.size()), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < txq.size())
        chk($sformatf("tx_byte%0d", i),
            32'(txq[i]), 32'(exp_tx[i]));
    end
    chk("tx_gap_ge3", 32'(min_gap >= 3), 1);
    chk("tx_gap_exact", 32'(min_gap), 3);

    // Bad CRC.
    fb[7] = 8'h0B;
    send_frame(8);
    chk("crc_err_pulse", 32'(n_crc), 1);
    chk("crc_no_req", 32'(req_valid_o), 0);
    chk("crc_idle", 32'(busy_o), 0);

    // Foreign address: silent drop.
    load_good(8'h05);
    send_frame(8);
    chk("foreign_no_req", 32'(req_valid_o), 0);
    chk("foreign_idle", 32'(busy_o), 0);
    chk("foreign_no_crc", 32'(n_crc), 1);

    // Broadcast.
    load_good(8'h00);
    send_frame(8);
    chk("bcast_req", 32'(req_valid_o), 1);
    chk("bcast_flag", 32'(req_bcast_o), 1);
    chk("bcast_len", 32'(req_len_o), 6);
    req_ack_i = 1'b1;
    tick();
    req_ack_i = 1'b0;
    chk("bcast_idle", 32'(busy_o), 0);
    base = txq.size();
    rsp_start_i = 1'b1;
    rsp_len_i = 4'd5;
    tick();
    rsp_start_i = 1'b0;
    repeat (10) tick();
    chk("bcast_rsp_ignored", 32'(busy_o), 0);
    chk("bcast_no_tx", 32'(txq.size()), 32'(base));

    // Overrun: 12 bytes into an 8-byte buffer.
    for (int i = 0; i < 12; i++) fb[i] = 8'(i + 1);
    send_frame(12);
    chk("overrun_pulse", 32'(n_ovr), 1);
    chk("overrun_idle", 32'(busy_o), 0);
    chk("overrun_no_req", 32'(req_valid_o), 0);

    // Short frame.
    send_frame(3);
    chk("short_pulse", 32'(n_short), 1);
    chk("short_idle", 32'(busy_o), 0);

    // Frame arriving while waiting for the app response.
    load_good(8'h01);
    send_frame(8);
    chk("drop_setup_req", 32'(req_valid_o), 1);
    req_ack_i = 1'b1;
    tick();
    req_ack_i = 1'b0;
    send_frame(3);
    chk("drop_pulse", 32'(n_drop), 1);
    chk("drop_busy", 32'(busy_o), 1);
    chk("drop_no_short", 32'(n_short), 1);

    // Reset mid-TX.
    base = txq.size();
    rsp_start_i = 1'b1;
    rsp_len_i = 4'd2;
    tick();
    rsp_start_i = 1'b0;
    k = 0;
    while (txq.size() == base && k < 50) begin
      tick();
      k++;
    end
    chk("midtx_first_byte", 32'(txq.size()), 32'(base + 1));
    rst = 1'b1;
    tick();
    chk("midtx_rst_txv", 32'(tx_valid_o), 0);
    chk("midtx_rst_busy", 32'(busy_o), 0);
    chk("midtx_rst_req", 32'(req_valid_o), 0);
    rst = 1'b0;
    repeat (10) tick();
    chk("midtx_no_more_tx", 32'(txq.size()), 32'(base + 1));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
